// File: rtl/raw_frame_gen.sv
// raw_frame_gen
// Synthetic raw Bayer (GRBG) camera source. It produces the same stream as
// the camera capture block: 12-bit pixels with data-valid, column/row
// counts, horizontal blanking after every line and vertical blanking after
// every frame. The patterns are deterministic (solid, ramp, colour bars,
// checker), so the downstream pipeline output can be predicted exactly.
//
// Ports:
//   iCLK          clock
//   iRST          asynchronous active-high reset
//   iEN           run enable, sampled in IDLE and at the end of a frame
//   iMODE[1:0]    pattern select, latched at frame start
//   iLEVEL[11:0]  solid-mode level, latched at frame start
//   oDATA[11:0]   raw Bayer pixel (0 outside active video)
//   oDVAL         pixel valid
//   oX_Cont[15:0] column of the current pixel
//   oY_Cont[15:0] row of the current pixel
//   oFrame_Start  one-cycle pulse together with pixel (0,0)
//   oFrame_Cnt    completed-frame count, wraps 65535 -> 0
module raw_frame_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 16,
    parameter int V_BLANK   = 4,
    parameter int RAMP_STEP = 4,
    parameter int BAR_SHIFT = 7
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iLEVEL,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic        oFrame_Start,
    output logic [15:0] oFrame_Cnt
);

    localparam int LINE   = H_ACTIVE + H_BLANK;
    localparam int VB_LEN = V_BLANK * LINE;
    localparam int B_MAX  = (VB_LEN > H_BLANK) ? VB_LEN : H_BLANK;
    localparam int BCW    = $clog2(B_MAX + 1);

    localparam logic [15:0]    X_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0]    Y_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [BCW-1:0] HB_LAST = BCW'(H_BLANK - 1);
    localparam logic [BCW-1:0] VB_LAST = BCW'(VB_LEN - 1);
    localparam logic [11:0]    RAMP12  = 12'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t         state, stateNxt;
    logic [BCW-1:0] blankCnt, blankNxt;
    logic [1:0]     modeReg;
    logic [11:0]    levelReg;

    logic [15:0]    xNxt, yNxt;
    logic           startFrame;   // next cycle shows pixel (0,0) of a new frame
    logic           cntInc;       // next cycle is the first VBLANK cycle

    logic [1:0]     modeUse;
    logic [11:0]    levelUse;
    logic [2:0]     bars;
    logic           chanBit;
    logic [11:0]    patVal;
    logic [11:0]    dataNxt;
    logic           dvalNxt;

    // State register plus the counters and registered outputs. The outputs
    // are computed one cycle ahead from the next state so that oDATA,
    // oX_Cont and oY_Cont always describe the same pixel.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state        <= IDLE;
            blankCnt     <= '0;
            modeReg      <= 2'd0;
            levelReg     <= 12'd0;
            oDATA        <= 12'd0;
            oDVAL        <= 1'b0;
            oX_Cont      <= 16'd0;
            oY_Cont      <= 16'd0;
            oFrame_Start <= 1'b0;
            oFrame_Cnt   <= 16'd0;
        end else begin
            state        <= stateNxt;
            blankCnt     <= blankNxt;
            if (startFrame) begin
                modeReg  <= iMODE;
                levelReg <= iLEVEL;
            end
            oDATA        <= dataNxt;
            oDVAL        <= dvalNxt;
            oX_Cont      <= xNxt;
            oY_Cont      <= yNxt;
            oFrame_Start <= startFrame;
            if (cntInc)
                oFrame_Cnt <= oFrame_Cnt + 16'd1;
        end
    end

    // Next-state logic. The column/row outputs double as the position
    // counters: X is 0 throughout blanking and restarts at 0 on every line.
    always_comb begin
        stateNxt   = state;
        blankNxt   = blankCnt;
        xNxt       = oX_Cont;
        yNxt       = oY_Cont;
        startFrame = 1'b0;
        cntInc     = 1'b0;
        case (state)
            IDLE: begin
                xNxt = 16'd0;
                yNxt = 16'd0;
                if (iEN) begin
                    stateNxt   = ACTIVE;
                    startFrame = 1'b1;
                end
            end
            ACTIVE: begin
                if (oX_Cont == X_LAST) begin
                    stateNxt = HBLANK;
                    xNxt     = 16'd0;
                    blankNxt = '0;
                end else begin
                    xNxt = oX_Cont + 16'd1;
                end
            end
            HBLANK: begin
                if (blankCnt == HB_LAST) begin
                    if (oY_Cont == Y_LAST) begin
                        stateNxt = VBLANK;
                        yNxt     = 16'd0;
                        blankNxt = '0;
                        cntInc   = 1'b1;
                    end else begin
                        stateNxt = ACTIVE;
                        yNxt     = oY_Cont + 16'd1;
                    end
                end else begin
                    blankNxt = blankCnt + 1'b1;
                end
            end
            VBLANK: begin
                if (blankCnt == VB_LAST) begin
                    // Back-to-back frames: no gap, straight into pixel (0,0).
                    if (iEN) begin
                        stateNxt   = ACTIVE;
                        startFrame = 1'b1;
                    end else begin
                        stateNxt = IDLE;
                    end
                end else begin
                    blankNxt = blankCnt + 1'b1;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Output logic: pattern value for the pixel that becomes visible next.
    // At a frame start the mode/level being latched must already apply.
    always_comb begin
        modeUse  = startFrame ? iMODE  : modeReg;
        levelUse = startFrame ? iLEVEL : levelReg;
        dvalNxt  = (stateNxt == ACTIVE);
        bars     = xNxt[BAR_SHIFT+2:BAR_SHIFT];
        // GRBG: even row G/R, odd row B/G; bar bits are R=2, G=1, B=0.
        if (!yNxt[0])
            chanBit = xNxt[0] ? bars[2] : bars[1];
        else
            chanBit = xNxt[0] ? bars[1] : bars[0];
        case (modeUse)
            2'd0:    patVal = levelUse;
            2'd1:    patVal = xNxt[11:0] * RAMP12;   // mod 4096 by truncation
            2'd2:    patVal = {12{chanBit}};
            default: patVal = {12{xNxt[3] ^ yNxt[3]}};
        endcase
        dataNxt = dvalNxt ? patVal : 12'd0;
    end

endmodule

// File: tb/tb_raw_frame_gen.sv
module tb_raw_frame_gen;

    localparam int H    = 16;
    localparam int V    = 10;
    localparam int HB   = 2;
    localparam int VB   = 1;
    localparam int RAMP = 300;   // wraps mod 4096 from X=14
    localparam int BS   = 0;
    localparam int LINE  = H + HB;
    localparam int FRAME = (V + VB) * LINE;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iEN = 1'b0;
    logic [1:0]  iMODE = 2'd0;
    logic [11:0] iLEVEL = 12'd0;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [15:0] oX_Cont, oY_Cont;
    logic        oFrame_Start;
    logic [15:0] oFrame_Cnt;

    raw_frame_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB),
        .RAMP_STEP(RAMP), .BAR_SHIFT(BS)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iMODE(iMODE), .iLEVEL(iLEVEL),
        .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
        .oFrame_Start(oFrame_Start), .oFrame_Cnt(oFrame_Cnt)
    );

    always #5 iCLK = ~iCLK;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position within the frame as a plain cycle index.
    bit mRun = 0;
    int mT = 0;
    int mMode = 0, mLevel = 0, mCnt = 0;

    function automatic int pat(int mode, int level, int x, int y);
        int b, ch;
        case (mode)
            0: return level;
            1: return (x * RAMP) % 4096;
            2: begin
                b = (x >> BS) % 8;
                if (y % 2 == 0) ch = (x % 2 == 0) ? (b >> 1) & 1 : (b >> 2) & 1;
                else            ch = (x % 2 == 0) ? b & 1        : (b >> 1) & 1;
                return ch ? 4095 : 0;
            end
            default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 4095 : 0;
        endcase
    endfunction

    task automatic modelStep();
        if (!mRun) begin
            if (iEN) begin
                mRun = 1; mT = 0; mMode = int'(iMODE); mLevel = int'(iLEVEL);
            end
        end else begin
            mT++;
            if (mT == V * LINE) mCnt = (mCnt + 1) % 65536;
            if (mT == FRAME) begin
                if (iEN) begin
                    mT = 0; mMode = int'(iMODE); mLevel = int'(iLEVEL);
                end else begin
                    mRun = 0;
                end
            end
        end
    endtask

    task automatic compareAll();
        int eData = 0, eVal = 0, eX = 0, eY = 0, eFs = 0;
        int line, col;
        if (mRun) begin
            line = mT / LINE;
            col  = mT % LINE;
            eFs  = (mT == 0) ? 1 : 0;
            if (line < V) begin
                eY = line;
                if (col < H) begin
                    eVal = 1; eX = col; eData = pat(mMode, mLevel, col, line);
                end
            end
        end
        check("dval",  int'(oDVAL), eVal);
        check("data",  int'(oDATA), eData);
        check("xcnt",  int'(oX_Cont), eX);
        check("ycnt",  int'(oY_Cont), eY);
        check("fstart", int'(oFrame_Start), eFs);
        check("fcnt",  int'(oFrame_Cnt), mCnt);
    endtask

    task automatic tick();
        @(posedge iCLK);
        if (!iRST) modelStep();
        #1 compareAll();
    endtask

    // Called 1 time unit after an edge: reset lands mid-cycle.
    task automatic pulseReset();
        #2 iRST = 1'b1;
        #1;
        mRun = 0; mT = 0; mCnt = 0;
        check("rst_async_dval", int'(oDVAL), 0);
        check("rst_async_data", int'(oDATA), 0);
        check("rst_async_x", int'(oX_Cont), 0);
        check("rst_async_y", int'(oY_Cont), 0);
        check("rst_async_fs", int'(oFrame_Start), 0);
        check("rst_async_fcnt", int'(oFrame_Cnt), 0);
        tick();
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    task automatic randPix();
        iMODE  = 2'($urandom_range(3));
        iLEVEL = 12'($urandom);
    endtask

    initial begin
        iRST = 1'b1;
        #12;
        compareAll();
        @(negedge iCLK);
        iRST = 1'b0;
        for (int i = 0; i < 5; i++) tick();   // enable low: stays idle

        // Continuous frames, mode/level churn every cycle.
        iEN = 1'b1;
        for (int i = 0; i < 8 * FRAME; i++) begin
            randPix();
            tick();
        end

        // Enable dropped long enough for the frame to finish and idle.
        iEN = 1'b0;
        for (int i = 0; i < FRAME + 40; i++) begin
            randPix();
            tick();
        end

        // Random enable toggling; only frame-end sampling matters.
        for (int i = 0; i < 6 * FRAME; i++) begin
            randPix();
            iEN = ($urandom_range(5) != 0);
            tick();
        end

        // Resets at random points, restarting with enable high.
        for (int r = 0; r < 3; r++) begin
            iEN = 1'b1;
            for (int i = 0; i < int'($urandom_range(FRAME - 1, 20)); i++) begin
                randPix();
                tick();
            end
            pulseReset();
            for (int i = 0; i < 2 * FRAME; i++) begin
                randPix();
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
